// File: rtl/cl_dmem_access.sv
// Data-memory access unit: turns one core load/store into a single-beat memory
// request with byte-lane steering, load-result extraction and a wait timeout.
`timescale 1ns/1ps
module cl_dmem_access #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              req_v_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic              is_byte_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              req_ready_o,
    output logic              rd_v_o,
    output logic [31:0]       rd_data_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_v_o,
    output logic              mem_w_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_yumi_i,
    input  logic              mem_rv_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0]  cnt_reg;
    logic              load_reg;
    logic              byte_reg;
    logic [1:0]        lane_reg;
    logic [ADDR_W-3:0] addr_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rd_data_reg;
    logic              rd_v_reg;
    logic              done_reg;
    logic              err_reg;

    logic        req_bad;
    logic        accept;
    logic        bad_req;
    logic        store_done;
    logic        load_done;
    logic        timeout_hit;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        wait_last;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_value;
    logic [7:0]  rdata_lane [4];
    logic [3:0]  lane_hot;

    // Per-lane decode: read-data byte extraction and one-hot lane enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata_lane[gi] = mem_rdata_i[8*gi +: 8];
            assign lane_hot[gi]   = (addr_i[1:0] == 2'(gi));
        end
    endgenerate

    // Word ops must be aligned and exactly one of load/store must be set.
    assign req_bad    = (!is_byte_i && (addr_i[1:0] != 2'b00)) || (is_load_i == is_store_i);
    assign be_next    = is_byte_i ? lane_hot : 4'b1111;
    assign wdata_next = is_byte_i ? {4{wdata_i[7:0]}} : wdata_i;
    assign load_value = byte_reg ? {24'h0, rdata_lane[lane_reg]} : mem_rdata_i;
    assign wait_last  = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        bad_req     = 1'b0;
        store_done  = 1'b0;
        load_done   = 1'b0;
        timeout_hit = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_v_i) begin
                    if (req_bad) begin
                        bad_req = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                // A handshake on the final wait cycle still wins over the timeout.
                if (mem_yumi_i) begin
                    if (!load_reg) begin
                        store_done = 1'b1;
                        state_next = IDLE;
                    end else if (mem_rv_i) begin
                        load_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_clr    = 1'b1;
                        state_next = RESP;
                    end
                end else if (wait_last) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (mem_rv_i) begin
                    load_done  = 1'b1;
                    state_next = IDLE;
                end else if (wait_last) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            load_reg    <= 1'b0;
            byte_reg    <= 1'b0;
            lane_reg    <= 2'b00;
            addr_reg    <= '0;
            be_reg      <= 4'b0000;
            wdata_reg   <= 32'h0;
            rd_data_reg <= 32'h0;
            rd_v_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (cnt_inc) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (accept) begin
                load_reg  <= is_load_i;
                byte_reg  <= is_byte_i;
                lane_reg  <= addr_i[1:0];
                addr_reg  <= addr_i[ADDR_W-1:2];
                be_reg    <= be_next;
                wdata_reg <= wdata_next;
            end
            if (load_done) begin
                rd_data_reg <= load_value;
            end
            rd_v_reg <= load_done;
            done_reg <= store_done | load_done;
            err_reg  <= bad_req | timeout_hit;
        end
    end

    // Request fields are only driven while the request is live.
    assign mem_v_o     = (state_reg == REQ);
    assign mem_w_o     = mem_v_o & ~load_reg;
    assign mem_addr_o  = mem_v_o ? addr_reg : '0;
    assign mem_be_o    = mem_v_o ? be_reg : 4'b0000;
    assign mem_wdata_o = mem_v_o ? wdata_reg : 32'h0;

    assign req_ready_o = (state_reg == IDLE) & n_reset;
    assign rd_v_o      = rd_v_reg;
    assign rd_data_o   = rd_data_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;

endmodule
